// File: rtl/line_store.sv
// Byte capture stage for the scan converter: tags each captured byte with a
// {line, col} frame-buffer address, queues it, and drains the queue to async SRAM.
module line_store #(
  parameter int COL_W      = 6,
  parameter int LINE_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              vd,
  input  logic                    save,
  output logic                    saved,
  input  logic                    hsync,
  input  logic                    vsync,
  output logic [COL_W+LINE_W-1:0] sram_addr,
  output logic [7:0]              sram_dq,
  output logic                    sram_ce_n,
  output logic                    sram_we_n,
  output logic                    overflow
);

  // state  | meaning
  // IDLE   | queue empty, SRAM deselected; pops as soon as an entry appears
  // SETUP  | address/data presented, chip enabled, write strobe high
  // STROBE | write strobe low for one cycle
  // HOLD   | strobe released, address/data held; pops the next entry if any

  localparam int AW = COL_W + LINE_W;
  localparam int EW = AW + 8;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state, state_nxt;
  logic              save_d, hsync_d, vsync_d;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic              col_full;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              cap, hs_rise, vs_rise;
  logic              fifo_empty, fifo_full;
  logic              pop, push, drop;

  assign cap        = save & ~save_d;
  assign hs_rise    = hsync & ~hsync_d;
  assign vs_rise    = vsync & ~vsync_d;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  // A full queue still accepts when the writer frees a slot on the same edge.
  assign push       = cap & ~col_full & (~fifo_full | pop);
  assign drop       = cap & ~push;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:  state_nxt = STROBE;
      STROBE: state_nxt = HOLD;
      HOLD: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_addr <= '0;
      sram_dq   <= '0;
    end else begin
      state     <= state_nxt;
      sram_ce_n <= (state_nxt == IDLE);
      sram_we_n <= (state_nxt != STROBE);
      if (pop) begin
        sram_addr <= mem[rd_ptr][EW-1:8];
        sram_dq   <= mem[rd_ptr][7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {line, col, vd};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Sync edges override the column increment of a coincident capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      save_d   <= 1'b0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
      col      <= '0;
      line     <= '0;
      col_full <= 1'b0;
      saved    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      save_d  <= save;
      hsync_d <= hsync;
      vsync_d <= vsync;
      saved   <= push;
      if (drop) overflow <= 1'b1;
      if (vs_rise) begin
        col      <= '0;
        line     <= '0;
        col_full <= 1'b0;
      end else if (hs_rise) begin
        col      <= '0;
        line     <= line + 1'b1;
        col_full <= 1'b0;
      end else if (push) begin
        col <= col + 1'b1;
        if (col == '1) col_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_store.sv
// Self-checking bench for line_store: directed vector table, corner sequences,
// and random stimulus checked against a transaction-level reference model.
module tb_line_store;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  vd;
  logic        save, hsync, vsync;
  logic        saved, sram_ce_n, sram_we_n, overflow;
  logic [14:0] sram_addr;
  logic [7:0]  sram_dq;

  line_store dut (
    .clk(clk), .reset(reset), .vd(vd), .save(save), .saved(saved),
    .hsync(hsync), .vsync(vsync), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: frame position rules, queue occupancy, and a writer that
  // can take a new entry at most once every 3 cycles.
  int          m_col, m_line, m_cnt, cyc, t_free;
  bit          m_full, m_ovf, m_saved, ps, ph, pv;
  logic [22:0] m_exp[$];

  always @(posedge clk) begin
    bit cap, hr, vr, do_pop, acc;
    logic [22:0] e;
    if (reset) begin
      m_exp.delete();
      m_col = 0; m_line = 0; m_cnt = 0; t_free = 0;
      m_full = 0; m_ovf = 0; m_saved = 0; ps = 0; ph = 0; pv = 0;
    end else begin
      cap    = save && !ps;
      hr     = hsync && !ph;
      vr     = vsync && !pv;
      do_pop = (m_cnt > 0) && (cyc >= t_free);
      acc    = cap && !m_full && ((m_cnt < 4) || do_pop);
      if (cap && !acc) m_ovf = 1;
      m_saved = acc;
      if (do_pop) begin
        m_cnt--;
        t_free = cyc + 3;
      end
      if (acc) begin
        e = {m_line[8:0], m_col[5:0], vd};
        m_exp.push_back(e);
        m_cnt++;
        if (m_col == 63) m_full = 1;
        m_col = (m_col + 1) % 64;
      end
      if (hr) begin
        m_col = 0; m_full = 0; m_line = (m_line + 1) % 512;
      end
      if (vr) begin
        m_col = 0; m_full = 0; m_line = 0;
      end
      ps = save; ph = hsync; pv = vsync;
    end
    cyc++;
  end

  // Output monitor, sampled mid-cycle.
  bit          mon_en = 0;
  bit          prev_we_low = 0;
  int          wr_cnt = 0;
  int          saved_cnt = 0;
  logic [22:0] act_log[$];

  always @(negedge clk) begin
    if (mon_en) begin
      check("saved", saved, m_saved);
      check("overflow", overflow, m_ovf);
      if (saved) saved_cnt++;
      if (sram_we_n === 1'b0) begin
        wr_cnt++;
        act_log.push_back({sram_addr, sram_dq});
        check("ce_n_during_strobe", sram_ce_n, 1'b0);
        if (prev_we_low) check("we_n_single_cycle", 1'b0, 1'b1);
        if (m_exp.size() == 0) begin
          check("unexpected_write_addr", sram_addr, 15'h7fff);
        end else begin
          check("wr_addr", sram_addr, m_exp[0][22:8]);
          check("wr_data", sram_dq, m_exp[0][7:0]);
          void'(m_exp.pop_front());
        end
      end
      prev_we_low = (sram_we_n === 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] v, input int gap);
    @(negedge clk);
    vd   = v;
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic pulse_hsync();
    @(negedge clk); hsync = 1'b1;
    repeat (4) @(negedge clk);
    hsync = 1'b0;
  endtask

  task automatic pulse_vsync();
    @(negedge clk); vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  typedef struct {
    int          pre;   // 0 none, 1 hsync pulse, 2 vsync pulse before the byte
    logic [7:0]  data;
    logic [14:0] addr;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[8];
    int w0, s0;
    bit found;
    logic [22:0] a;

    vecs[0] = '{0, 8'h11, 15'h000};
    vecs[1] = '{0, 8'h22, 15'h001};
    vecs[2] = '{0, 8'h33, 15'h002};
    vecs[3] = '{0, 8'h44, 15'h003};
    vecs[4] = '{0, 8'h55, 15'h004};
    vecs[5] = '{1, 8'hA0, 15'h040};
    vecs[6] = '{0, 8'hA1, 15'h041};
    vecs[7] = '{2, 8'hB0, 15'h000};

    reset = 1'b1; vd = 8'h00; save = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_saved", saved, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_ce_n", sram_ce_n, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_addr", sram_addr, 15'h0);
    check("rst_dq", sram_dq, 8'h0);
    mon_en = 1;
    reset  = 1'b0;

    // Directed vector table
    act_log.delete();
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre == 1) pulse_hsync();
      if (vecs[i].pre == 2) pulse_vsync();
      send_byte(vecs[i].data, 8);
      if (act_log.size() == 0) begin
        check("vec_write_seen", 1'b0, 1'b1);
      end else begin
        a = act_log.pop_front();
        check("vec_addr", a[22:8], vecs[i].addr);
        check("vec_data", a[7:0], vecs[i].data);
      end
    end

    // Save held high: one capture only
    w0 = wr_cnt; s0 = saved_cnt;
    @(negedge clk); vd = 8'h5A; save = 1'b1;
    repeat (10) @(negedge clk);
    save = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_save_writes", wr_cnt - w0, 1);
    check("hold_save_saved", saved_cnt - s0, 1);

    // 65 bytes on one line
    pulse_vsync();
    act_log.delete();
    w0 = wr_cnt; s0 = saved_cnt;
    for (int i = 0; i < 65; i++) send_byte(8'(i + 3), 8);
    repeat (8) @(negedge clk);
    check("line_full_writes", wr_cnt - w0, 64);
    check("line_full_saved", saved_cnt - s0, 64);
    check("line_full_ovf", overflow, 1'b1);
    if (act_log.size() == 64) begin
      check("line_first_addr", act_log[0][22:8], 15'h000);
      check("line_last_addr", act_log[63][22:8], 15'h03f);
    end else begin
      check("line_log_size", act_log.size(), 64);
    end
    pulse_hsync();
    pulse_vsync();
    send_byte(8'hC3, 8);
    check("ovf_sticky", overflow, 1'b1);
    do_reset();
    check("ovf_cleared", overflow, 1'b0);

    // Captures faster than the drain rate
    w0 = wr_cnt; s0 = saved_cnt;
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 2);
    repeat (30) @(negedge clk);
    check("fast_ovf", overflow, 1'b1);
    check("fast_all_written", wr_cnt - w0, saved_cnt - s0);
    check("fast_some_dropped", (saved_cnt - s0) < 20, 1'b1);

    // Reset during the write strobe, with entries still queued
    do_reset();
    pulse_hsync();
    for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sram_we_n === 1'b0) found = 1;
    end
    check("strobe_reached", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we_n", sram_we_n, 1'b1);
    check("rst_mid_ce_n", sram_ce_n, 1'b1);
    check("rst_mid_saved", saved, 1'b0);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("rst_mid_fifo_empty", wr_cnt - w0, 0);
    act_log.delete();
    send_byte(8'h77, 8);
    if (act_log.size() == 0) begin
      check("post_rst_write_seen", 1'b0, 1'b1);
    end else begin
      check("post_rst_addr", act_log[0][22:8], 15'h000);
      check("post_rst_data", act_log[0][7:0], 8'h77);
    end

    // Random per-cycle stimulus against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      vd   = 8'($urandom);
      save = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 5) hsync = ~hsync;
      if ($urandom_range(0, 99) < 2) vsync = ~vsync;
    end
    save = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (30) @(negedge clk);
    check("drain_complete", m_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
